// File: rtl/serdes_pkg.sv
// Shared serdes definitions: FSM state encoding and bit-order selectors.
// Used by the transmit serializer and the receive-side capture chains.
package serdes_pkg;

  // Serializer/deserializer frame state
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } serdes_state_e;

  // Bit order selectors for the LSB_FIRST parameter
  localparam bit MSB_FIRST = 1'b0;
  localparam bit LSB_FIRST = 1'b1;

endpackage : serdes_pkg

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shift register with valid/ready load handshake.
// A frame is WIDTH bits, marked by ser_first/ser_last, closed by a done pulse.
// A word may be accepted on the edge that consumes the last bit, so frames
// can run back to back with no idle gap.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             done
);

  import serdes_pkg::*;

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               SEND_LSB = (LSB_FIRST == serdes_pkg::LSB_FIRST);

  serdes_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_first_q, ser_first_d;
  logic             ser_last_q, ser_last_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] shreg_shifted;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_last;
  logic             accept;

  // Shifted register image (vacated bit fills with 0) and counter helpers
  always_comb begin
    shreg_shifted = {WIDTH{1'b0}};
    if (SEND_LSB) begin
      shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end else begin
      shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end
    cnt_inc  = cnt_q + CNT_ONE;
    cnt_last = (cnt_q == CNT_LAST);
  end

  // Ready when idle, or when the last bit of the frame is consumed this cycle
  always_comb begin
    load_ready = 1'b0;
    case (state_q)
      ST_IDLE:  load_ready = 1'b1;
      ST_SHIFT: load_ready = cnt_last & ser_en;
      default:  load_ready = 1'b0;
    endcase
    accept = load_valid & load_ready;
  end

  // Next-state logic: load, advance, stall and frame-end handling
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    ser_valid_d = ser_valid_q;
    ser_first_d = ser_first_q;
    ser_last_d  = ser_last_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_SHIFT;
          cnt_d       = {CNT_W{1'b0}};
          shreg_d     = load_data;
          ser_valid_d = 1'b1;
          ser_first_d = 1'b1;
          ser_last_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (ser_en) begin
          if (cnt_last) begin
            done_d = 1'b1;
            if (accept) begin
              state_d     = ST_SHIFT;
              cnt_d       = {CNT_W{1'b0}};
              shreg_d     = load_data;
              ser_valid_d = 1'b1;
              ser_first_d = 1'b1;
              ser_last_d  = 1'b0;
            end else begin
              // Shifting out the final bit leaves the register all zero
              state_d     = ST_IDLE;
              cnt_d       = {CNT_W{1'b0}};
              shreg_d     = shreg_shifted;
              ser_valid_d = 1'b0;
              ser_first_d = 1'b0;
              ser_last_d  = 1'b0;
            end
          end else begin
            cnt_d       = cnt_inc;
            shreg_d     = shreg_shifted;
            ser_first_d = 1'b0;
            ser_last_d  = (cnt_inc == CNT_LAST);
          end
        end else begin
          // Stall: everything holds
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = {CNT_W{1'b0}};
        shreg_d     = {WIDTH{1'b0}};
        ser_valid_d = 1'b0;
        ser_first_d = 1'b0;
        ser_last_d  = 1'b0;
      end
    endcase
  end

  // State, counter, shift register and flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      shreg_q     <= {WIDTH{1'b0}};
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      ser_valid_q <= ser_valid_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
      done_q      <= done_d;
    end
  end

  assign ser_out   = SEND_LSB ? shreg_q[0] : shreg_q[WIDTH-1];
  assign ser_valid = ser_valid_q;
  assign ser_first = ser_first_q;
  assign ser_last  = ser_last_q;
  assign done      = done_q;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share
// stimulus; a queue-based frame model is compared on every falling edge,
// and directed frames are pinned against hand-computed literals.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk, reset_n, load_valid, ser_en;
  logic [W-1:0] load_data;
  logic         m_ready, m_out, m_valid, m_first, m_last, m_done;
  logic         l_ready, l_out, l_valid, l_first, l_last, l_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: bits still to be presented for the current frame, in send order
  bit   q_m[$];
  bit   q_l[$];
  logic exp_done;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_ready(m_ready),
    .load_data(load_data), .ser_en(ser_en), .ser_out(m_out), .ser_valid(m_valid),
    .ser_first(m_first), .ser_last(m_last), .done(m_done)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_ready(l_ready),
    .load_data(load_data), .ser_en(ser_en), .ser_out(l_out), .ser_valid(l_valid),
    .ser_first(l_first), .ser_last(l_last), .done(l_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      q_m.push_back(w[W-1-i]);
      q_l.push_back(w[i]);
    end
  endtask

  // Model update: consume the front bit when enabled; a word is taken
  // whenever the frame in flight has been fully consumed
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_m.delete();
      q_l.delete();
      exp_done <= 1'b0;
    end else begin
      exp_done <= (q_m.size() == 1) && ser_en;
      if (q_m.size() > 0 && ser_en) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
      if (load_valid && q_m.size() == 0) push_word(load_data);
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    check1("ready_msb", m_ready, (q_m.size() == 0) || (q_m.size() == 1 && ser_en));
    check1("valid_msb", m_valid, q_m.size() > 0);
    check1("out_msb",   m_out,   (q_m.size() > 0) ? q_m[0] : 1'b0);
    check1("first_msb", m_first, q_m.size() == W);
    check1("last_msb",  m_last,  q_m.size() == 1);
    check1("done_msb",  m_done,  exp_done);
    check1("ready_lsb", l_ready, (q_l.size() == 0) || (q_l.size() == 1 && ser_en));
    check1("valid_lsb", l_valid, q_l.size() > 0);
    check1("out_lsb",   l_out,   (q_l.size() > 0) ? q_l[0] : 1'b0);
    check1("first_lsb", l_first, q_l.size() == W);
    check1("last_lsb",  l_last,  q_l.size() == 1);
    check1("done_lsb",  l_done,  exp_done);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    load_valid = 1'b0;
    ser_en     = 1'b1;
    repeat (12) tick();
  endtask

  // One frame accepted at edge 0; optional second word offered from cycle
  // w2_from and held until accepted; ser_en low on cycles st_lo..st_hi.
  // Masks carry one bit per cycle 1..ncyc; bits collect consumed ser_out.
  task automatic directed(input logic [W-1:0] w1, input logic [W-1:0] w2,
                          input int w2_from, input int st_lo, input int st_hi,
                          input int ncyc,
                          output logic [31:0] bm, output logic [31:0] bl,
                          output logic [31:0] fm, output logic [31:0] lm,
                          output logic [31:0] dm, output logic [31:0] vm,
                          output logic [31:0] rm);
    logic acc;
    bm = 32'h0; bl = 32'h0; fm = 32'h0; lm = 32'h0;
    dm = 32'h0; vm = 32'h0; rm = 32'h0;
    load_valid = 1'b1;
    load_data  = w1;
    ser_en     = 1'b1;
    tick();
    load_valid = 1'b0;
    load_data  = 8'($urandom);
    for (int k = 1; k <= ncyc; k++) begin
      if (k == w2_from) begin
        load_valid = 1'b1;
        load_data  = w2;
      end
      ser_en = !(k >= st_lo && k <= st_hi);
      @(negedge clk);
      if (m_valid && ser_en) bm = {bm[30:0], m_out};
      if (l_valid && ser_en) bl = {bl[30:0], l_out};
      fm[k] = m_first;
      lm[k] = m_last;
      dm[k] = m_done;
      vm[k] = m_valid;
      rm[k] = m_ready;
      acc   = load_valid && m_ready;
      tick();
      if (acc) begin
        load_valid = 1'b0;
        load_data  = 8'($urandom);
      end
    end
  endtask

  logic [31:0] bm, bl, fm, lm, dm, vm, rm;
  int          dcount;
  logic        acc_r;

  initial begin
    reset_n    = 1'b0;
    load_valid = 1'b0;
    ser_en     = 1'b0;
    load_data  = 8'h00;
    @(negedge clk);
    check32("reset_outs_msb", {27'h0, m_out, m_valid, m_first, m_last, m_done}, 32'h0);
    check32("reset_outs_lsb", {27'h0, l_out, l_valid, l_first, l_last, l_done}, 32'h0);
    check1("reset_ready", m_ready, 1'b1);
    #2 reset_n = 1'b1;
    settle();

    // Single MSB/LSB frame of 0xA5
    directed(8'hA5, 8'h00, 0, 0, -1, 9, bm, bl, fm, lm, dm, vm, rm);
    check32("a5_bits_msb", bm, 32'h000000A5);
    check32("a5_bits_lsb", bl, 32'h000000A5);
    check32("a5_first",    fm, 32'h00000002);
    check32("a5_last",     lm, 32'h00000100);
    check32("a5_done",     dm, 32'h00000200);
    check32("a5_valid",    vm, 32'h000001FE);
    check32("a5_ready",    rm, 32'h00000300);
    settle();

    // 0x01 distinguishes the two bit orders
    directed(8'h01, 8'h00, 0, 0, -1, 9, bm, bl, fm, lm, dm, vm, rm);
    check32("01_bits_msb", bm, 32'h00000001);
    check32("01_bits_lsb", bl, 32'h00000080);
    settle();

    // Back-to-back 0xA5 then 0x3C
    directed(8'hA5, 8'h3C, 1, 0, -1, 17, bm, bl, fm, lm, dm, vm, rm);
    check32("b2b_bits_msb", bm, 32'h0000A53C);
    check32("b2b_bits_lsb", bl, 32'h0000A53C);
    check32("b2b_first",    fm, 32'h00000202);
    check32("b2b_last",     lm, 32'h00010100);
    check32("b2b_done",     dm, 32'h00020200);
    check32("b2b_valid",    vm, 32'h0001FFFE);
    check32("b2b_ready",    rm, 32'h00030100);
    settle();

    // Stall on cycles 3..5
    directed(8'hF0, 8'h00, 0, 3, 5, 12, bm, bl, fm, lm, dm, vm, rm);
    check32("stall_bits_msb", bm, 32'h000000F0);
    check32("stall_bits_lsb", bl, 32'h0000000F);
    check32("stall_last",     lm, 32'h00000800);
    check32("stall_done",     dm, 32'h00001000);
    check32("stall_valid",    vm, 32'h00000FFE);
    check32("stall_ready",    rm, 32'h00001800);
    settle();

    // Busy: 0x55 offered from cycle 3, taken only at frame end
    directed(8'hA5, 8'h55, 3, 0, -1, 17, bm, bl, fm, lm, dm, vm, rm);
    check32("busy_bits_msb", bm, 32'h0000A555);
    check32("busy_bits_lsb", bl, 32'h0000A5AA);
    check32("busy_first",    fm, 32'h00000202);
    check32("busy_done",     dm, 32'h00020200);
    check32("busy_ready",    rm, 32'h00030100);
    settle();

    // Reset in the middle of a frame
    load_valid = 1'b1;
    load_data  = 8'hA5;
    ser_en     = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    check32("midrst_outs_msb", {27'h0, m_out, m_valid, m_first, m_last, m_done}, 32'h0);
    check32("midrst_outs_lsb", {27'h0, l_out, l_valid, l_first, l_last, l_done}, 32'h0);
    check1("midrst_ready", m_ready, 1'b1);
    dcount = 0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_done || l_done) dcount++;
    end
    check32("midrst_no_done", dcount, 32'h0);
    tick();
    directed(8'h81, 8'h00, 0, 0, -1, 9, bm, bl, fm, lm, dm, vm, rm);
    check32("post_rst_bits_msb", bm, 32'h00000081);
    check32("post_rst_bits_lsb", bl, 32'h00000081);
    check32("post_rst_done",     dm, 32'h00000200);
    settle();

    // Randomized traffic: producer holds word until accepted, random stalls
    load_valid = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      acc_r = load_valid && m_ready;
      tick();
      if (acc_r || !load_valid) begin
        load_valid = ($urandom_range(0, 2) != 0);
        load_data  = 8'($urandom);
      end
      ser_en = ($urandom_range(0, 3) != 0);
    end
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_piso_serializer
